mod_counter_n: RTL and testbench



---
 rtl/mod_counter_pkg.sv | 14 +
 rtl/mod_counter_n_tick_prescaler.sv | 24 ++
 rtl/mod_counter_n.sv | 139 +++++++++++++
 tb/tb_mod_counter_n.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types for the parametrised modulo counter: count modes and direction encoding.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_BOUNCE  = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mod_counter_n_tick_prescaler.sv
// Tick prescaler: one tick every prescale+1 enabled cycles; clr restarts the divider.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = ena && (cnt == prescale);

  // A divider left above a lowered prescale clears on the next enabled cycle without ticking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ena) cnt <= (cnt >= prescale) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/mod_counter_n.sv
// Parametrised modulo counter core: four count modes, prescaled ticks, parallel load,
// compare match and a one-cycle terminal-count pulse.
module mod_counter_n
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned MODULO     = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  tc,
  output logic                  done,
  output logic                  cmp_match
);

  if ((MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_bad_modulo
    $error("mod_counter_n: MODULO must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MODULO - 2);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  mode_e            m;
  logic             tick;
  logic [WIDTH-1:0] count_n;
  logic             dir_n, tc_n, done_n;

  assign m         = mode_e'(mode);
  assign cmp_match = (count == cmp_val);

  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      dir   <= DIR_UP;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_n;
      dir   <= dir_n;
      tc    <= tc_n;
      done  <= done_n;
    end
  end

  always_comb begin
    count_n = count;
    dir_n   = dir;
    tc_n    = 1'b0;
    done_n  = done;
    // Leaving one-shot mode releases done on the next edge, tick or not.
    if (m != MODE_ONESHOT) done_n = 1'b0;
    if (load) begin
      count_n = (load_val > MAX) ? MAX : load_val;
      dir_n   = (m == MODE_DOWN) ? DIR_DOWN : DIR_UP;
      done_n  = 1'b0;
    end else if (tick) begin
      unique case (m)
        MODE_UP: begin
          dir_n = DIR_UP;
          if (count == MAX) begin
            count_n = '0;
            tc_n    = 1'b1;
          end else begin
            count_n = count + 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_n = DIR_DOWN;
          if (count == '0) begin
            count_n = MAX;
            tc_n    = 1'b1;
          end else begin
            count_n = count - 1'b1;
          end
        end
        MODE_ONESHOT: begin
          dir_n = DIR_UP;
          if (!done) begin
            if (count == MAX) begin
              done_n = 1'b1;
            end else begin
              count_n = count + 1'b1;
              if (count == MAX_M1) begin
                tc_n   = 1'b1;
                done_n = 1'b1;
              end
            end
          end
        end
        MODE_BOUNCE: begin
          // Entering bounce already sitting on the endpoint ahead reflects without a tc.
          if (dir == DIR_UP) begin
            if (count == MAX) begin
              count_n = count - 1'b1;
              dir_n   = DIR_DOWN;
            end else begin
              count_n = count + 1'b1;
              if (count == MAX_M1) begin
                tc_n  = 1'b1;
                dir_n = DIR_DOWN;
              end
            end
          end else begin
            if (count == '0) begin
              count_n = count + 1'b1;
              dir_n   = DIR_UP;
            end else begin
              count_n = count - 1'b1;
              if (count == ONE) begin
                tc_n  = 1'b1;
                dir_n = DIR_UP;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_counter_n.sv
// Randomised scoreboard bench for mod_counter_n with a behavioural reference model.
module tb_mod_counter_n;

  localparam int W   = 3;
  localparam int MOD = 6;
  localparam int PW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  cmp_val = '0;
  logic [W-1:0]  count;
  logic          dir, tc, done, cmp_match;

  mod_counter_n #(.WIDTH(W), .MODULO(MOD), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .load(load),
    .load_val(load_val), .prescale(prescale), .cmp_val(cmp_val),
    .count(count), .dir(dir), .tc(tc), .done(done), .cmp_match(cmp_match)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit dir;
    bit tc;
    bit done;
    bit cm;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state.
  int m_cnt, m_pre;
  bit m_dir, m_done, m_tc;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_dir = 0; m_done = 0; m_tc = 0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit en, input int ps, input int md);
    bit tk;
    int nxt;
    tk   = en && (m_pre == ps);
    if (en) m_pre = (m_pre >= ps) ? 0 : m_pre + 1;
    m_tc = 0;
    if (md != 2) m_done = 0;
    if (ld) begin
      m_cnt  = (lv > MOD - 1) ? MOD - 1 : lv;
      m_pre  = 0;
      m_done = 0;
      m_dir  = (md == 1);
    end else if (tk) begin
      case (md)
        0: begin m_dir = 0; m_tc = (m_cnt == MOD - 1); m_cnt = (m_cnt + 1) % MOD; end
        1: begin m_dir = 1; m_tc = (m_cnt == 0); m_cnt = (m_cnt + MOD - 1) % MOD; end
        2: begin
          m_dir = 0;
          if (!m_done) begin
            if (m_cnt >= MOD - 1) m_done = 1;
            else begin
              m_cnt++;
              if (m_cnt == MOD - 1) begin m_tc = 1; m_done = 1; end
            end
          end
        end
        default: begin
          nxt = m_cnt + (m_dir ? -1 : 1);
          if (nxt < 0 || nxt > MOD - 1) begin
            m_cnt = m_cnt - (nxt - m_cnt);
            m_dir = !m_dir;
          end else begin
            m_cnt = nxt;
            if (nxt == 0 || nxt == MOD - 1) begin m_tc = 1; m_dir = !m_dir; end
          end
        end
      endcase
    end
  endtask

  task automatic drive(input bit ld, input int lv, input bit en, input int ps, input int md, input int cv);
    exp_t e;
    @(negedge clk);
    load = ld; load_val = lv[W-1:0]; ena = en; prescale = ps[PW-1:0];
    mode = md[1:0]; cmp_val = cv[W-1:0];
    model_step(ld, lv, en, ps, md);
    e.cnt = m_cnt; e.dir = m_dir; e.tc = m_tc; e.done = m_done; e.cm = (m_cnt == cv);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_done", int'(done), 0);
    check("rst_cmp_match", int'(cmp_match), int'(cmp_val == '0));
    model_reset();
    #4 rst_n = 1'b1;
  endtask

  // Monitor: outputs are valid every cycle; compare one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 1) check("queue_backlog", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.cnt);
        check("dir", int'(dir), int'(e.dir));
        check("tc", int'(tc), int'(e.tc));
        check("done", int'(done), int'(e.done));
        check("cmp_match", int'(cmp_match), int'(e.cm));
      end
    end
  end

  initial begin
    int md;
    model_reset();
    do_reset();

    // Free-up wrap, then run to 4 and reset mid-count.
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 2, 1, 0);

    // Free-down with prescale 2.
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 2, 1, 5);
    do_reset();

    // One-shot to the top, extra ticks ignored, load releases done.
    for (int i = 0; i < 15; i++) drive(0, 0, 1, 0, 2, 5);
    drive(1, 2, 1, 0, 2, 2);
    drive(0, 0, 1, 0, 2, 2);
    do_reset();

    // Bounce through both endpoints.
    for (int i = 0; i < 12; i++) drive(0, 0, 1, 0, 3, 0);

    // Clamped load coincident with a tick.
    drive(1, 7, 1, 0, 0, 5);
    drive(0, 0, 1, 1, 0, 5);
    drive(0, 0, 1, 1, 0, 5);

    md = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) md = int'($urandom_range(3));
      if ($urandom_range(250) == 0) do_reset();
      drive($urandom_range(19) == 0, int'($urandom_range(7)), $urandom_range(9) != 0,
            ($urandom_range(7) == 0) ? int'($urandom_range(15)) : int'($urandom_range(2)),
            md, int'($urandom_range(7)));
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
